// File: rtl/alu_pkg.sv
// Shared ALU encodings: ALUCtl codes, ALUOp values and R-type Funct fields.
// Used by the issue queue, its decoder, the ALU and their benches.
package alu_pkg;

    localparam int unsigned ALUCTL_W = 4;
    localparam int unsigned ALUOP_W  = 2;
    localparam int unsigned FUNCT_W  = 6;

    localparam logic [ALUCTL_W-1:0] ALUCTL_AND     = 4'b0000;
    localparam logic [ALUCTL_W-1:0] ALUCTL_OR      = 4'b0001;
    localparam logic [ALUCTL_W-1:0] ALUCTL_ADD     = 4'b0010;
    localparam logic [ALUCTL_W-1:0] ALUCTL_SUB     = 4'b0110;
    localparam logic [ALUCTL_W-1:0] ALUCTL_SLT     = 4'b0111;
    localparam logic [ALUCTL_W-1:0] ALUCTL_NOR     = 4'b1100;
    localparam logic [ALUCTL_W-1:0] ALUCTL_ILLEGAL = 4'b1111;

    localparam logic [ALUOP_W-1:0] ALUOP_ADD     = 2'b00;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB     = 2'b01;
    localparam logic [ALUOP_W-1:0] ALUOP_RTYPE   = 2'b10;
    localparam logic [ALUOP_W-1:0] ALUOP_ILLEGAL = 2'b11;

    localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'b100000;
    localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'b100010;
    localparam logic [FUNCT_W-1:0] FUNCT_AND = 6'b100100;
    localparam logic [FUNCT_W-1:0] FUNCT_OR  = 6'b100101;
    localparam logic [FUNCT_W-1:0] FUNCT_NOR = 6'b100111;
    localparam logic [FUNCT_W-1:0] FUNCT_SLT = 6'b101010;

endpackage

// File: rtl/alu_ctl_decode.sv
// Combinational ALUOp/Funct to ALUCtl translation with an illegal-opcode flag.
module alu_ctl_decode
    import alu_pkg::*;
(
    input  logic [ALUOP_W-1:0]  alu_op,
    input  logic [FUNCT_W-1:0]  funct,
    output logic [ALUCTL_W-1:0] alu_ctl_c,
    output logic                illegal_c
);

    always_comb begin
        alu_ctl_c = ALUCTL_ILLEGAL;
        illegal_c = 1'b1;
        case (alu_op)
            ALUOP_ADD: begin
                alu_ctl_c = ALUCTL_ADD;
                illegal_c = 1'b0;
            end
            ALUOP_SUB: begin
                alu_ctl_c = ALUCTL_SUB;
                illegal_c = 1'b0;
            end
            ALUOP_RTYPE: begin
                illegal_c = 1'b0;
                case (funct)
                    FUNCT_ADD: alu_ctl_c = ALUCTL_ADD;
                    FUNCT_SUB: alu_ctl_c = ALUCTL_SUB;
                    FUNCT_AND: alu_ctl_c = ALUCTL_AND;
                    FUNCT_OR:  alu_ctl_c = ALUCTL_OR;
                    FUNCT_NOR: alu_ctl_c = ALUCTL_NOR;
                    FUNCT_SLT: alu_ctl_c = ALUCTL_SLT;
                    default:   illegal_c = 1'b1;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_issue_queue.sv
// In-order operand/opcode FIFO in front of the ALU; decodes ALUCtl at enqueue.
// Macro ALU_ISSUE_ILLEGAL_TRAP_EN: drop illegal entries and raise sticky IllegalOp.
module alu_issue_queue
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       InValid,
    output logic                       InReady,
    input  logic [WIDTH-1:0]           InA,
    input  logic [WIDTH-1:0]           InB,
    input  logic [ALUOP_W-1:0]         InALUOp,
    input  logic [FUNCT_W-1:0]         InFunct,
    output logic                       OutValid,
    input  logic                       OutReady,
    output logic [WIDTH-1:0]           OutA,
    output logic [WIDTH-1:0]           OutB,
    output logic [ALUCTL_W-1:0]        OutALUCtl,
    output logic [$clog2(DEPTH+1)-1:0] Count,
    output logic                       IllegalOp
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]    mem_a   [DEPTH];
    logic [WIDTH-1:0]    mem_b   [DEPTH];
    logic [ALUCTL_W-1:0] mem_ctl [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    cnt;

    logic [ALUCTL_W-1:0] dec_ctl;
    logic                dec_illegal;
    logic [ALUCTL_W-1:0] enq_ctl;
    logic                push;
    logic                pop;
    logic                wr;

    alu_ctl_decode u_decode (
        .alu_op    (InALUOp),
        .funct     (InFunct),
        .alu_ctl_c (dec_ctl),
        .illegal_c (dec_illegal)
    );

    assign enq_ctl  = dec_illegal ? ALUCTL_ILLEGAL : dec_ctl;
    assign InReady  = (cnt != CNT_W'(DEPTH));
    assign OutValid = (cnt != CNT_W'(0));
    assign push     = InValid && InReady;
    assign pop      = OutValid && OutReady;
    assign Count    = cnt;

`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    // Illegal entries complete the handshake but never occupy a slot.
    assign wr = push && !dec_illegal;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            IllegalOp <= 1'b0;
        end else if (push && dec_illegal) begin
            IllegalOp <= 1'b1;
        end
    end
`else
    assign wr        = push;
    assign IllegalOp = 1'b0;
`endif

    // Storage is cleared on reset so the head outputs read zero afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_a[i]   <= '0;
                mem_b[i]   <= '0;
                mem_ctl[i] <= '0;
            end
        end else if (wr) begin
            mem_a[wr_ptr]   <= InA;
            mem_b[wr_ptr]   <= InB;
            mem_ctl[wr_ptr] <= enq_ctl;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: ;
            endcase
        end
    end

    assign OutA      = mem_a[rd_ptr];
    assign OutB      = mem_b[rd_ptr];
    assign OutALUCtl = mem_ctl[rd_ptr];

endmodule

// File: tb/tb_alu_issue_queue.sv
// Self-checking bench for alu_issue_queue: directed scenarios plus random traffic
// against a queue-based reference model. Honours ALU_ISSUE_ILLEGAL_TRAP_EN.
module tb_alu_issue_queue;

    localparam int DEPTH = 4;
    localparam int WIDTH = 32;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctl;
    } ent_t;

    localparam logic [5:0] FUNCTS [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
    localparam logic [3:0] CODES  [6] = '{4'h2,  4'h6,  4'h0,  4'h1,  4'hC,  4'h7};

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [1:0]  in_alu_op;
    logic [5:0]  in_funct;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [3:0]  out_ctl;
    logic [2:0]  count;
    logic        illegal_op;

    int   checks = 0;
    int   errors = 0;
    ent_t exp_q[$];
    bit   exp_ill = 1'b0;

    alu_issue_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .InValid   (in_valid),
        .InReady   (in_ready),
        .InA       (in_a),
        .InB       (in_b),
        .InALUOp   (in_alu_op),
        .InFunct   (in_funct),
        .OutValid  (out_valid),
        .OutReady  (out_ready),
        .OutA      (out_a),
        .OutB      (out_b),
        .OutALUCtl (out_ctl),
        .Count     (count),
        .IllegalOp (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference decode: {illegal, code}.
    function automatic logic [4:0] ref_decode(input logic [1:0] op, input logic [5:0] f);
        if (op == 2'd0) return {1'b0, 4'h2};
        if (op == 2'd1) return {1'b0, 4'h6};
        if (op == 2'd2) begin
            for (int i = 0; i < 6; i++) begin
                if (f == FUNCTS[i]) return {1'b0, CODES[i]};
            end
        end
        return {1'b1, 4'hF};
    endfunction

    function automatic logic [5:0] pick_funct();
        if ($urandom_range(0, 7) != 0) return FUNCTS[$urandom_range(0, 5)];
        return 6'($urandom);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        ent_t h;
        chk({tag, "_count"},   32'(count),      32'(exp_q.size()));
        chk({tag, "_outvalid"}, 32'(out_valid), 32'(exp_q.size() != 0));
        chk({tag, "_inready"},  32'(in_ready),  32'(exp_q.size() != DEPTH));
        chk({tag, "_illegal"},  32'(illegal_op), 32'(exp_ill));
        if (exp_q.size() != 0) begin
            h = exp_q[0];
            chk({tag, "_outa"},   out_a,         h.a);
            chk({tag, "_outb"},   out_b,         h.b);
            chk({tag, "_outctl"}, 32'(out_ctl),  32'(h.ctl));
        end
    endtask

    task automatic put(input logic v, input logic [1:0] op, input logic [5:0] f, input logic r);
        in_valid  = v;
        in_alu_op = op;
        in_funct  = f;
        in_a      = $urandom;
        in_b      = $urandom;
        out_ready = r;
    endtask

    // One clock: update the model from pre-edge inputs, then compare after the edge.
    task automatic step(input string tag);
        int         n;
        bit         do_push;
        bit         do_pop;
        logic [4:0] d;
        ent_t       e;
        n       = exp_q.size();
        do_push = in_valid && (n != DEPTH);
        do_pop  = out_ready && (n != 0);
        d       = ref_decode(in_alu_op, in_funct);
        e.a     = in_a;
        e.b     = in_b;
        e.ctl   = d[3:0];
        @(posedge clk);
        #1;
        if (do_pop) void'(exp_q.pop_front());
        if (do_push) begin
            if (d[4] && TRAP) exp_ill = 1'b1;
            else exp_q.push_back(e);
        end
        check_state(tag);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < DEPTH + 1; i++) begin
            put(1'b0, 2'd0, 6'd0, 1'b1);
            step(tag);
        end
    endtask

    initial begin
        reset = 1'b1;
        put(1'b0, 2'd0, 6'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count",    32'(count),      32'd0);
        chk("rst_outvalid", 32'(out_valid),  32'd0);
        chk("rst_inready",  32'(in_ready),   32'd1);
        chk("rst_illegal",  32'(illegal_op), 32'd0);
        chk("rst_outa",     out_a,           32'd0);
        chk("rst_outb",     out_b,           32'd0);
        chk("rst_outctl",   32'(out_ctl),    32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // R-type AND, visible next cycle, then popped.
        put(1'b1, 2'b10, 6'b100100, 1'b0);
        in_a = 32'hF0F0_F0F0;
        in_b = 32'h0FF0_0FF0;
        step("t1_push");
        chk("t1_and_code", 32'(out_ctl), 32'h0);
        put(1'b0, 2'd0, 6'd0, 1'b1);
        step("t1_pop");

        // Fill with add, sub, slt, nor; fifth offer ignored; drain in order.
        put(1'b1, 2'b00, 6'd0, 1'b0);       step("t2_add");
        put(1'b1, 2'b01, 6'd0, 1'b0);       step("t2_sub");
        put(1'b1, 2'b10, 6'b101010, 1'b0);  step("t2_slt");
        put(1'b1, 2'b10, 6'b100111, 1'b0);  step("t2_nor");
        chk("t2_full_inready", 32'(in_ready), 32'd0);
        put(1'b1, 2'b00, 6'd0, 1'b0);       step("t2_fifth");
        put(1'b0, 2'd0, 6'd0, 1'b1);
        chk("t2_head_add", 32'(out_ctl), 32'h2);  step("t2_d0");
        chk("t2_head_sub", 32'(out_ctl), 32'h6);  step("t2_d1");
        chk("t2_head_slt", 32'(out_ctl), 32'h7);  step("t2_d2");
        chk("t2_head_nor", 32'(out_ctl), 32'hC);  step("t2_d3");

        // Full queue with push and pop offered together: pop only.
        for (int i = 0; i < DEPTH; i++) begin
            put(1'b1, 2'b10, pick_funct(), 1'b0);
            in_alu_op = 2'(($urandom_range(0, 2)));
            in_funct  = FUNCTS[$urandom_range(0, 5)];
            step("t3_fill");
        end
        put(1'b1, 2'b00, 6'd0, 1'b1);
        step("t3_full_pushpop");
        chk("t3_count3", 32'(count), 32'd3);
        drain("t3_drain");

        // Steady push+pop stream, pointers wrap several times.
        put(1'b1, 2'b00, 6'd0, 1'b0);
        step("t4_prime");
        for (int i = 0; i < 20; i++) begin
            put(1'b1, 2'b10, FUNCTS[$urandom_range(0, 5)], 1'b1);
            step("t4_stream");
        end
        drain("t4_drain");

        // Illegal opcodes: ALUOp 11 and an unknown R-type funct.
        put(1'b1, 2'b11, 6'b000000, 1'b0);
        step("t5_illop");
        put(1'b1, 2'b10, 6'b000000, 1'b0);
        step("t5_badfunct");
        put(1'b1, 2'b00, 6'd0, 1'b0);
        step("t5_after");
        drain("t5_drain");

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            put(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), pick_funct(),
                1'($urandom_range(0, 2) != 0));
            if (in_alu_op == 2'b11 && $urandom_range(0, 3) != 0) in_alu_op = 2'b10;
            step("rnd");
        end
        drain("rnd_drain");

        // Asynchronous reset with three entries held.
        for (int i = 0; i < 3; i++) begin
            put(1'b1, 2'b00, 6'd0, 1'b0);
            step("t6_fill");
        end
        put(1'b0, 2'd0, 6'd0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_async_outvalid", 32'(out_valid), 32'd0);
        chk("t6_async_count",    32'(count),     32'd0);
        chk("t6_async_illegal",  32'(illegal_op), 32'd0);
        exp_q.delete();
        exp_ill = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        put(1'b1, 2'b01, 6'd0, 1'b0);
        step("t6_post");
        drain("t6_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
